puzzle_board_ctrl: RTL

- Owns the 3x3 sliding-puzzle board state: tiles 1..8 plus one blank, stored as value 0.
- Sequences a solvable shuffle by applying random legal moves from the solved position, then accepts player moves and detects the solved condition.
- Drives row1/row2/row3 packed nibbles straight into the 7-segment row display mux.
- Move and start inputs are single-cycle pulses from the upstream button edge-detect/debounce stage.

---
 rtl/puzzle_board_ctrl_if.sv | 29 ++
 rtl/puzzle_board_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/puzzle_board_ctrl_if.sv
// Button-pulse inputs and display/status outputs of the 3x3 sliding-puzzle board.
// The slave modport is the board controller; the master modport is the button/display side.
interface puzzle_board_ctrl_if #(
  parameter int MOVE_W = 10
);
  logic              start;
  logic              mv_up;
  logic              mv_down;
  logic              mv_left;
  logic              mv_right;
  logic [11:0]       row1;
  logic [11:0]       row2;
  logic [11:0]       row3;
  logic [3:0]        blank_pos;
  logic [MOVE_W-1:0] move_count;
  logic              busy;
  logic              solved;
  logic [1:0]        state;

  modport slave (
    input  start, mv_up, mv_down, mv_left, mv_right,
    output row1, row2, row3, blank_pos, move_count, busy, solved, state
  );

  modport master (
    output start, mv_up, mv_down, mv_left, mv_right,
    input  row1, row2, row3, blank_pos, move_count, busy, solved, state
  );
endinterface

// File: rtl/puzzle_board_ctrl.sv
// 3x3 sliding-puzzle board: LFSR-driven solvable shuffle, player moves, solved detection.
// Board cell i lives in r_board[i]; the blank is stored as value 0.
module puzzle_board_ctrl #(
  parameter int          SHUFFLE_MOVES = 64,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter int          MOVE_W        = 10
) (
  input logic                clk,
  input logic                clr,
  puzzle_board_ctrl_if.slave pb
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SHUFFLE = 2'd1,
    S_PLAY    = 2'd2,
    S_SOLVED  = 2'd3
  } state_t;

  localparam logic [35:0] SOLVED_BOARD = 36'h0_8765_4321;
  localparam logic [15:0] LFSR_INIT    = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [7:0]  SHUF_LOAD    = 8'(SHUFFLE_MOVES);

  // Direction encoding: 0 up, 1 down, 2 left, 3 right.
  function automatic logic f_legal(input logic [3:0] b, input logic [1:0] d);
    case (d)
      2'd0:    f_legal = (b >= 4'd3);
      2'd1:    f_legal = (b <= 4'd5);
      2'd2:    f_legal = ((b % 4'd3) != 4'd0);
      default: f_legal = ((b % 4'd3) != 4'd2);
    endcase
  endfunction

  function automatic logic [3:0] f_target(input logic [3:0] b, input logic [1:0] d);
    case (d)
      2'd0:    f_target = b - 4'd3;
      2'd1:    f_target = b + 4'd3;
      2'd2:    f_target = b - 4'd1;
      default: f_target = b + 4'd1;
    endcase
  endfunction

  function automatic logic [MOVE_W-1:0] f_sat_inc(input logic [MOVE_W-1:0] m);
    f_sat_inc = (m == '1) ? m : m + 1'b1;
  endfunction

  state_t            r_state, w_state_nxt;
  logic [8:0][3:0]   r_board, w_board_nxt;
  logic [3:0]        r_blank, w_blank_nxt;
  logic [7:0]        r_shuf_cnt, w_shuf_cnt_nxt;
  logic [MOVE_W-1:0] r_move_cnt, w_move_cnt_nxt;
  logic [15:0]       r_lfsr, w_lfsr_nxt;
  logic              r_busy, r_solved;
  logic [3:0]        w_mv_vec;
  logic [1:0]        w_play_dir, w_dir;
  logic              w_do_swap;
  logic [3:0]        w_tgt;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state    <= S_IDLE;
      r_board    <= SOLVED_BOARD;
      r_blank    <= 4'd8;
      r_shuf_cnt <= 8'd0;
      r_move_cnt <= '0;
      r_lfsr     <= LFSR_INIT;
      r_busy     <= 1'b0;
      r_solved   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_board    <= w_board_nxt;
      r_blank    <= w_blank_nxt;
      r_shuf_cnt <= w_shuf_cnt_nxt;
      r_move_cnt <= w_move_cnt_nxt;
      r_lfsr     <= w_lfsr_nxt;
      r_busy     <= (w_state_nxt == S_SHUFFLE);
      r_solved   <= (w_state_nxt == S_SOLVED);
    end
  end

  always_comb begin
    w_lfsr_nxt     = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    w_mv_vec       = {pb.mv_right, pb.mv_left, pb.mv_down, pb.mv_up};
    w_play_dir     = 2'd0;
    case (w_mv_vec)
      4'b0010: w_play_dir = 2'd1;
      4'b0100: w_play_dir = 2'd2;
      4'b1000: w_play_dir = 2'd3;
      default: w_play_dir = 2'd0;
    endcase

    w_state_nxt    = r_state;
    w_board_nxt    = r_board;
    w_blank_nxt    = r_blank;
    w_shuf_cnt_nxt = r_shuf_cnt;
    w_move_cnt_nxt = r_move_cnt;
    w_do_swap      = 1'b0;
    w_dir          = 2'd0;
    w_tgt          = r_blank;

    case (r_state)
      S_IDLE, S_SOLVED: begin
        if (pb.start) begin
          w_state_nxt    = S_SHUFFLE;
          w_shuf_cnt_nxt = SHUF_LOAD;
          w_move_cnt_nxt = '0;
        end
      end
      S_SHUFFLE: begin
        // A shuffle that happens to land back on the solved board keeps going one move at a time.
        if (r_shuf_cnt == 8'd0) begin
          if (r_board != SOLVED_BOARD) w_state_nxt    = S_PLAY;
          else                         w_shuf_cnt_nxt = 8'd1;
        end else begin
          w_dir = r_lfsr[1:0];
          if (f_legal(r_blank, w_dir)) begin
            w_do_swap      = 1'b1;
            w_shuf_cnt_nxt = r_shuf_cnt - 8'd1;
          end
        end
      end
      default: begin
        if (pb.start) begin
          w_state_nxt    = S_SHUFFLE;
          w_shuf_cnt_nxt = SHUF_LOAD;
          w_move_cnt_nxt = '0;
        end else if (r_board == SOLVED_BOARD) begin
          w_state_nxt = S_SOLVED;
        end else if ($onehot(w_mv_vec) && f_legal(r_blank, w_play_dir)) begin
          w_dir          = w_play_dir;
          w_do_swap      = 1'b1;
          w_move_cnt_nxt = f_sat_inc(r_move_cnt);
        end
      end
    endcase

    if (w_do_swap) begin
      w_tgt                = f_target(r_blank, w_dir);
      w_board_nxt[r_blank] = r_board[w_tgt];
      w_board_nxt[w_tgt]   = 4'd0;
      w_blank_nxt          = w_tgt;
    end
  end

  assign pb.row1       = {r_board[0], r_board[1], r_board[2]};
  assign pb.row2       = {r_board[3], r_board[4], r_board[5]};
  assign pb.row3       = {r_board[6], r_board[7], r_board[8]};
  assign pb.blank_pos  = r_blank;
  assign pb.move_count = r_move_cnt;
  assign pb.busy       = r_busy;
  assign pb.solved     = r_solved;
  assign pb.state      = r_state;

endmodule
